// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit codes, serial-controller states, legality helper.
package ternary_pkg;

  localparam logic [1:0] T0   = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TINV = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // A trit is legal unless it carries the unused code.
  function automatic logic trit_legal(input logic [1:0] t);
    return t != TINV;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational ternary full subtractor: t = a - b - c, diff = t mod 3, b_out = borrow trit.
module full_subtractor (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic [1:0] diff,
  output logic [1:0] b_out
);

  logic signed [3:0] t;
  logic signed [3:0] m;

  // Fold the raw difference back into 0..2 and report how many threes were borrowed.
  always_comb begin
    t     = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({2'b00, c});
    m     = t;
    b_out = 2'b00;
    if (t < -4'sd3) begin
      m     = t + 4'sd6;
      b_out = 2'b10;
    end else if (t < 4'sd0) begin
      m     = t + 4'sd3;
      b_out = 2'b01;
    end else if (t >= 4'sd3) begin
      m     = t - 4'sd3;
    end
    diff = m[1:0];
  end

endmodule

// File: rtl/ternary_serial_sub.sv
// Trit-serial ternary subtractor: one trit per clock, LSB first, with operand validation.
module ternary_serial_sub
  import ternary_pkg::*;
#(
  parameter int unsigned N_TRITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*N_TRITS-1:0] a,
  input  logic [2*N_TRITS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [2*N_TRITS-1:0] diff,
  output logic [1:0]           borrow_out,
  output logic                 err
);

  localparam int unsigned W    = 2 * N_TRITS;
  localparam int unsigned IdxW = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_TRITS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, diff_q;
  logic [1:0]      borrow_q, bout_q;
  logic            err_q;
  logic [IdxW-1:0] idx_q;

  logic            ops_legal;
  logic            accept;
  logic            last_trit;
  logic [1:0]      a_trit, b_trit, fs_diff, fs_bout;

  // Both operands must be free of the illegal code to start a real subtraction.
  always_comb begin
    ops_legal = 1'b1;
    for (int i = 0; i < int'(N_TRITS); i++) begin
      if (!trit_legal(a[2*i +: 2]) || !trit_legal(b[2*i +: 2])) ops_legal = 1'b0;
    end
  end

  assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_trit = (idx_q == LastIdx);
  assign a_trit    = a_q[{idx_q, 1'b0} +: 2];
  assign b_trit    = b_q[{idx_q, 1'b0} +: 2];

  full_subtractor u_fs (
    .a     (a_trit),
    .b     (b_trit),
    .c     (borrow_q),
    .diff  (fs_diff),
    .b_out (fs_bout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state: illegal operands skip RUN entirely and report through DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = ops_legal ? StRun : StDone;
        else        state_d = StIdle;
      end
      StRun:   state_d = last_trit ? StDone : StRun;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode directly from the state, so busy and done are exclusive.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath: operand capture at accept, one result trit and borrow update per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 2'b00;
      bout_q   <= 2'b00;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else if (accept) begin
      diff_q   <= '0;
      borrow_q <= 2'b00;
      bout_q   <= 2'b00;
      idx_q    <= '0;
      if (ops_legal) begin
        a_q   <= a;
        b_q   <= b;
        err_q <= 1'b0;
      end else begin
        err_q <= 1'b1;
      end
    end else if (state_q == StRun) begin
      diff_q[{idx_q, 1'b0} +: 2] <= fs_diff;
      borrow_q                   <= fs_bout;
      if (last_trit) begin
        bout_q <= fs_bout;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ternary_serial_sub.sv
// Directed self-checking bench for ternary_serial_sub with N_TRITS = 4.
module tb_ternary_serial_sub;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] a, b;
  logic           busy, done, err;
  logic [2*N-1:0] diff;
  logic [1:0]     borrow_out;

  int errors = 0;
  int checks = 0;

  ternary_serial_sub #(.N_TRITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full legal operation: busy for edges k..k+N-1, done after edge k+N.
  task automatic do_op(input string tag, input logic [2*N-1:0] av, input logic [2*N-1:0] bv,
                       input logic [2*N-1:0] exp_diff, input logic [1:0] exp_bout);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_diff"}, diff, exp_diff);
    chk({tag, "_bout"}, borrow_out, exp_bout);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", borrow_out, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    // 2101 - 0012 = 2012
    do_op("normal", 8'b10_01_00_01, 8'b00_00_01_10, 8'b10_00_01_10, 2'b00);
    step();
    chk("normal_done_pulse", done, 0);
    chk("normal_diff_held", diff, 8'b10_00_01_10);

    // 0000 - 0001 wraps to 2222 with borrow
    do_op("under", 8'h00, 8'h01, 8'hAA, 2'b01);
    step();

    // 2222 - 2222, then back-to-back start in the DONE cycle
    do_op("equal", 8'hAA, 8'hAA, 8'h00, 2'b00);
    do_op("b2b", 8'h01, 8'h01, 8'h00, 2'b00);
    step();

    // Illegal trit goes straight to DONE with err
    a = 8'b00_00_00_11;
    b = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_diff", diff, 0);
    chk("ill_bout", borrow_out, 0);
    chk("ill_busy", busy, 0);
    step();
    chk("ill_done_pulse", done, 0);
    chk("ill_busy2", busy, 0);
    chk("ill_err_held", err, 1);

    // Start during RUN is ignored; only one done
    a = 8'b10_01_00_01;
    b = 8'b00_00_01_10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 8'h00;
    b = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bign_busy", busy, 1);
    chk("bign_err_cleared", err, 0);
    step();
    chk("bign_nodone", done, 0);
    step();
    chk("bign_done", done, 1);
    chk("bign_diff", diff, 8'b10_00_01_10);
    chk("bign_bout", borrow_out, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bign_single_done", done, 0);
      chk("bign_no_busy", busy, 0);
    end

    // Reset mid-run aborts immediately; a fresh op then completes
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_diff", diff, 0);
    chk("mid_bout", borrow_out, 0);
    chk("mid_err", err, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_done", done, 0);
    end
    do_op("after_rst", 8'hAA, 8'h55, 8'h55, 2'b00);
    // 0010 - 0002 = 0001
    do_op("borrow_mid", 8'b00_00_01_00, 8'b00_00_00_10, 8'h01, 2'b00);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
